// File: rtl/fc_layer_scheduler_pkg.sv
// rtl/fc_layer_scheduler_pkg.sv - shared types and constants for the FC layer scheduler
package fc_layer_scheduler_pkg;

  localparam int ADDR_W = 16;

  localparam int CFG_IS_WR_BIT = 0;
  localparam int CFG_LAYER_LSB = 1;
  localparam int CFG_LAYER_MSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/fc_mem_mux.sv
// rtl/fc_mem_mux.sv - combinational layer select and base-address add for the shared data memory
module fc_mem_mux
  import fc_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = 2
) (
  input  logic                         active,
  input  logic [1:0]                   sel,
  input  logic [NUM_LAYERS-1:0]        lyr_we,
  input  logic [ADDR_W*NUM_LAYERS-1:0] lyr_addr,
  input  logic [ADDR_W*NUM_LAYERS-1:0] lyr_out,
  input  logic [ADDR_W*NUM_LAYERS-1:0] rd_base,
  input  logic [ADDR_W*NUM_LAYERS-1:0] wr_base,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_wdata
);

  // Sum is truncated to ADDR_W bits, so base + offset wraps silently.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (active && sel == 2'(k)) begin
        mem_we    = lyr_we[k];
        mem_wdata = lyr_out[k*ADDR_W +: ADDR_W];
        mem_addr  = (lyr_we[k] ? wr_base[k*ADDR_W +: ADDR_W] : rd_base[k*ADDR_W +: ADDR_W])
                    + lyr_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/fc_layer_scheduler.sv
// rtl/fc_layer_scheduler.sv - sequences FC layer engines and arbitrates their shared data memory
module fc_layer_scheduler
  import fc_layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_idx,
  input  logic [15:0]                  cfg_data,
  output logic [NUM_LAYERS-1:0]        lyr_enable,
  input  logic [NUM_LAYERS-1:0]        lyr_end,
  input  logic [NUM_LAYERS-1:0]        lyr_we,
  input  logic [ADDR_W*NUM_LAYERS-1:0] lyr_addr,
  input  logic [ADDR_W*NUM_LAYERS-1:0] lyr_out,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [1:0]                   cur_layer
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t                         state;
  logic [WD_W-1:0]                watchdog;
  logic [ADDR_W*NUM_LAYERS-1:0]   rd_base;
  logic [ADDR_W*NUM_LAYERS-1:0]   wr_base;
  logic                           cur_end;
  logic                           last_layer;
  logic                           cfg_open;
  logic [1:0]                     cfg_layer;
  logic [NUM_LAYERS-1:0]          next_enable;

  assign cfg_open    = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign cfg_layer   = cfg_idx[CFG_LAYER_MSB:CFG_LAYER_LSB];
  assign last_layer  = (cur_layer == 2'(NUM_LAYERS - 1));
  assign next_enable = NUM_LAYERS'(1) << (cur_layer + 2'd1);

  // Only the current layer's end strobe matters; the rest are don't-care.
  always_comb begin
    cur_end = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cur_layer == 2'(k)) cur_end = lyr_end[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_base <= '0;
      wr_base <= '0;
    end else if (cfg_we && cfg_open) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (cfg_layer == 2'(k)) begin
          if (cfg_idx[CFG_IS_WR_BIT]) wr_base[k*ADDR_W +: ADDR_W] <= cfg_data;
          else                        rd_base[k*ADDR_W +: ADDR_W] <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      watchdog    <= '0;
      lyr_enable  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cur_layer   <= 2'd0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= ST_IDLE;
        lyr_enable  <= '0;
        busy        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_RUN;
              cur_layer  <= 2'd0;
              watchdog   <= '0;
              lyr_enable <= NUM_LAYERS'(1);
              busy       <= 1'b1;
            end
          end
          ST_RUN: begin
            if (cur_end) begin
              state      <= ST_GAP;
              lyr_enable <= '0;
            end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
              state       <= ST_ERR;
              lyr_enable  <= '0;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              watchdog <= watchdog + 1'b1;
            end
          end
          ST_GAP: begin
            if (last_layer) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= ST_RUN;
              cur_layer  <= cur_layer + 2'd1;
              watchdog   <= '0;
              lyr_enable <= next_enable;
            end
          end
          ST_DONE: state <= ST_IDLE;
          ST_ERR: begin
            if (start) begin
              state       <= ST_IDLE;
              timeout_err <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  fc_mem_mux #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_mem_mux (
    .active   (state == ST_RUN),
    .sel      (cur_layer),
    .lyr_we   (lyr_we),
    .lyr_addr (lyr_addr),
    .lyr_out  (lyr_out),
    .rd_base  (rd_base),
    .wr_base  (wr_base),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata)
  );

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// tb/tb_fc_layer_scheduler.sv - scoreboard bench for fc_layer_scheduler
module tb_fc_layer_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [15:0] cfg_data = '0;
  logic [1:0]  lyr_enable;
  logic [1:0]  lyr_end;
  logic [1:0]  lyr_we = '0;
  logic [31:0] lyr_addr = '0;
  logic [31:0] lyr_out = '0;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, busy, done, timeout_err;
  logic [1:0]  cur_layer;

  logic        t_en, t_mem_we, t_busy, t_done, t_err;
  logic [15:0] t_mem_addr, t_mem_wdata;
  logic [1:0]  t_cur;
  logic        t_end = 1'b0;
  logic        t_we = 1'b0;
  logic [15:0] t_addr = '0;
  logic [15:0] t_out = '0;

  fc_layer_scheduler #(.NUM_LAYERS(2), .TIMEOUT(65535)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .lyr_enable(lyr_enable), .lyr_end(lyr_end), .lyr_we(lyr_we),
    .lyr_addr(lyr_addr), .lyr_out(lyr_out),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .timeout_err(timeout_err), .cur_layer(cur_layer)
  );

  fc_layer_scheduler #(.NUM_LAYERS(1), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .lyr_enable(t_en), .lyr_end(t_end), .lyr_we(t_we),
    .lyr_addr(t_addr), .lyr_out(t_out),
    .mem_addr(t_mem_addr), .mem_we(t_mem_we), .mem_wdata(t_mem_wdata),
    .busy(t_busy), .done(t_done), .timeout_err(t_err), .cur_layer(t_cur)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int len [2] = '{50, 30};
  int cnt [2] = '{0, 0};
  int t_done_cnt = 0;
  logic [1:0] prev_en = '0;
  bit mon_en = 1'b0;
  bit done_seen = 1'b0;
  logic [1:0] exp_en[$];
  int exp_done[$];

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } mem_exp_t;
  mem_exp_t mem_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (t_done) t_done_cnt <= t_done_cnt + 1;

  // Layer engine model: end is raised during the len-th enabled cycle.
  always @(posedge clk)
    for (int k = 0; k < 2; k++) cnt[k] <= lyr_enable[k] ? cnt[k] + 1 : 0;
  always_comb
    for (int k = 0; k < 2; k++) lyr_end[k] = lyr_enable[k] && (cnt[k] == len[k] - 1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && lyr_enable !== prev_en) begin
      if (exp_en.size() > 0) check("enable_seq", {30'b0, lyr_enable}, {30'b0, exp_en.pop_front()});
      else check("enable_extra", {30'b0, lyr_enable}, {30'b0, prev_en});
    end
    prev_en <= lyr_enable;
    if (done) begin
      done_seen <= 1'b1;
      if (exp_done.size() > 0) check("done_cycle", cyc, exp_done.pop_front());
      else check("done_unexpected", {31'b0, done}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] layer, input logic is_wr, input logic [15:0] data);
    cfg_we = 1'b1;
    cfg_idx = {layer, is_wr};
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_layer1(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (lyr_enable == 2'b10) ok = 1'b1;
      else tick();
    end
    check(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic drive_l1(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] out, input logic [15:0] exp_addr);
    mem_exp_t e;
    lyr_we[1] = we;
    lyr_addr[31:16] = addr;
    lyr_out[31:16] = out;
    mem_q.push_back('{addr: exp_addr, we: we, wdata: out});
    #1;
    e = mem_q.pop_front();
    check({tag, "_addr"}, {16'b0, mem_addr}, {16'b0, e.addr});
    check({tag, "_we"}, {31'b0, mem_we}, {31'b0, e.we});
    check({tag, "_wdata"}, {16'b0, mem_wdata}, {16'b0, e.wdata});
  endtask

  initial begin
    int k0;
    bit in_gap;
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_enable", {30'b0, lyr_enable}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, timeout_err}, 32'd0);
    check("rst_cur", {30'b0, cur_layer}, 32'd0);
    check("rst_mem", {mem_addr, mem_wdata}, 32'd0);

    cfg_write(2'd0, 1'b0, 16'h0000);
    cfg_write(2'd1, 1'b0, 16'h0100);
    cfg_write(2'd0, 1'b1, 16'h0100);
    cfg_write(2'd1, 1'b1, 16'h0200);

    // Two-layer pass: 84 cycles from the start cycle through the done cycle.
    exp_en = '{2'b01, 2'b00, 2'b10, 2'b00};
    mon_en = 1'b1;
    k0 = cyc;
    exp_done.push_back(k0 + 84 - 1);
    pulse_start();
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    check("pass_done_seen", {31'b0, done_seen}, 32'd1);
    tick();
    mon_en = 1'b0;
    check("pass_enable_left", exp_en.size(), 32'd0);
    check("pass_idle_busy", {31'b0, busy}, 32'd0);

    // Abort mid-layer, then start+abort together.
    len = '{1000, 1000};
    pulse_start();
    tick();
    check("abort_pre_en", {30'b0, lyr_enable}, 32'd1);
    pulse_abort();
    check("abort_en", {30'b0, lyr_enable}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {31'b0, busy}, 32'd0);
    check("start_abort_en", {30'b0, lyr_enable}, 32'd0);

    // Address mapping on layer 1 with the bases written before the abort.
    len = '{3, 100000};
    pulse_start();
    wait_layer1("map_reach");
    drive_l1("map_rd", 1'b0, 16'h0005, 16'h0000, 16'h0105);
    drive_l1("map_wr", 1'b1, 16'h0005, 16'h1234, 16'h0205);
    pulse_abort();
    check("mem_idle", {15'b0, mem_we, mem_addr}, 32'd0);
    cfg_write(2'd1, 1'b1, 16'hFFFF);
    pulse_start();
    wait_layer1("wrap_reach");
    drive_l1("wrap", 1'b1, 16'h0002, 16'h00AA, 16'h0001);
    lyr_we = '0;

    // Config writes are locked while a pass is running.
    cfg_write(2'd1, 1'b0, 16'hABCD);
    drive_l1("lock_run", 1'b0, 16'h0005, 16'h0000, 16'h0105);
    pulse_abort();
    cfg_write(2'd1, 1'b0, 16'hABCD);
    pulse_start();
    wait_layer1("lock_reach");
    drive_l1("lock_idle", 1'b0, 16'h0005, 16'h0000, 16'hABD2);
    pulse_abort();

    // Watchdog on the TIMEOUT=16 instance: 16 RUN cycles then ERR.
    t_done_cnt = 0;
    pulse_start();
    repeat (15) tick();
    check("to_not_yet_err", {31'b0, t_err}, 32'd0);
    check("to_still_en", {31'b0, t_en}, 32'd1);
    tick();
    check("to_err", {31'b0, t_err}, 32'd1);
    check("to_en_low", {31'b0, t_en}, 32'd0);
    repeat (5) tick();
    check("to_err_held", {31'b0, t_err}, 32'd1);
    check("to_no_done", t_done_cnt, 32'd0);
    pulse_start();
    check("to_cleared", {31'b0, t_err}, 32'd0);
    pulse_start();
    check("to_restart_en", {31'b0, t_en}, 32'd1);
    check("to_restart_cur", {30'b0, t_cur}, 32'd0);
    pulse_abort();

    // Reset for one edge while in GAP.
    len = '{3, 3};
    pulse_start();
    in_gap = 1'b0;
    for (int i = 0; i < 20 && !in_gap; i++) begin
      tick();
      if (busy && lyr_enable == 2'b00) in_gap = 1'b1;
    end
    check("gap_found", {31'b0, in_gap}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_en", {30'b0, lyr_enable}, 32'd0);
    check("mid_rst_flags", {29'b0, busy, done, timeout_err}, 32'd0);
    check("mid_rst_cur", {30'b0, cur_layer}, 32'd0);
    check("mid_rst_mem", {mem_addr, mem_wdata}, 32'd0);
    len = '{3, 100000};
    pulse_start();
    wait_layer1("rst_base_reach");
    drive_l1("rst_base", 1'b0, 16'h0005, 16'h0000, 16'h0005);
    pulse_abort();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
